calc_input_sequencer: RTL
=========================

// Module: calc_input_sequencer
// PURPOSE
//   Command sequencer between the UART byte receiver and the calculator ALU.
//   Parses received ASCII keys into operand A, operator and operand B, then runs a valid/ready/done handshake with the ALU.
//   Publishes the result with a one-cycle strobe to the display buffer, and issues buffer-clear pulses.
// PARAMETERS
//   WIDTH        16    operand/result width, unsigned binary
//   MAX_DIGITS   4     max decimal digits per operand; extra digits dropped
//   TIMEOUT_CYC  1024  WAIT-state watchdog limit in clk cycles (TIMEOUT_EN only)
// PORTS
//   clk           in   1      system clock
//   reset         in   1      asynchronous, active-low reset
//   rx_valid      in   1      byte-ready level from the receiver; byte taken on rising edge
//   rx_data       in   8      received ASCII byte
//   alu_start     out  1      request; held until alu_ready
//   alu_ready     in   1      ALU accepts the request this cycle
//   alu_op        out  2      operator: 0 '+', 1 '-', 2 '*', 3 '/'
//   alu_a         out  WIDTH  operand A
//   alu_b         out  WIDTH  operand B
//   alu_done      in   1      one-cycle result strobe
//   alu_result    in   WIDTH  result, valid with alu_done
//   alu_error     in   1      error flag (e.g. divide by 0), valid with alu_done
//   result        out  WIDTH  last good result
//   result_valid  out  1      one-cycle pulse when result updates (display submit)
//   buf_clear     out  1      one-cycle pulse on clear
//   busy          out  1      1 in EXEC or WAIT
//   error         out  1      1 while in ERR
//   state         out  3      current FSM state code
// BEHAVIOUR
//   - Reset: all outputs 0, state=IDLE, accumulators, digit count, pending-clear 0. Async assert: alu_start drops at once.
//   - Byte accept: rx_valid & ~rx_valid_q, where rx_valid_q is a 1-cycle registered copy. Classes: digit '0'-'9'; op '+' '-' '*' '/'; eq '=' or 0x0D; clr 'C'/'c'. Others ignored.
//   - Accumulate: acc <= acc*10 + d in WIDTH+4 bits, saturate at 2^WIDTH-1. Digit ignored when count == MAX_DIGITS.
//   - States: IDLE=0, OPA=1, OPB=2, EXEC=3, WAIT=4, SHOW=5, ERR=6.
//   - IDLE: digit -> A=d, cnt=1, OPA. op and eq ignored.
//   - OPA: digit accumulates. op -> latch alu_op, B=0, cnt=0, OPB. eq ignored.
//   - OPB: digit accumulates. op with cnt==0 replaces alu_op; op with cnt>0 ignored. eq with cnt>0 -> EXEC; eq with cnt==0 ignored.
//   - EXEC: alu_start=1, alu_a/alu_b/alu_op stable. On alu_start & alu_ready -> WAIT; alu_start low from next cycle.
//   - WAIT: on alu_done: if alu_error=0, result<=alu_result, result_valid pulses next cycle, -> SHOW. If alu_error=1 -> ERR, result kept.
//   - SHOW: digit -> A=d, OPA. op -> chain: A=result, latch op, OPB.
//   - ERR: error=1; only clr leaves.
//   - clr in IDLE/OPA/OPB/SHOW/ERR: zero A, B, counts; buf_clear pulse next cycle; -> IDLE.
//   - clr in EXEC/WAIT: sets pending-clear. Handshake completes normally. On leaving WAIT, go to IDLE and pulse buf_clear. Suppress result_valid; do not update result.
//   - Non-clr bytes in EXEC/WAIT dropped, including a byte in the same cycle as alu_done.
//   - alu_done outside WAIT ignored.
//   - Latency: final eq byte edge -> alu_start high next cycle. alu_done -> result_valid 1 cycle later.
// CONFIGURATION
//   TIMEOUT_WATCHDOG_EN defined: cycle counter runs in WAIT, cleared on entry.
//     - Reaching TIMEOUT_CYC without alu_done -> ERR (pending-clear -> IDLE).
//     - Late alu_done then ignored.
//   Undefined: no counter; WAIT holds until alu_done.
// TESTING
//   1 "12+34=", alu_ready=1, done after 3 cycles with 46 -> alu_a=12, alu_b=34, op=0; alu_start 1 cycle; result=46; result_valid 1 pulse; state=5.
//   2 "12345+" -> alu_a=1234; "7+-3=" -> alu_op=1, alu_b=3.
//   3 alu_ready low 5 cycles in EXEC -> alu_start high 5+1 cycles, operands unchanged; then "*2=" after 46 -> alu_a=46, op=2.
//   4 "9/0=", done with alu_error=1 -> state=6, error=1, result unchanged; digits ignored; 'c' -> IDLE, buf_clear 1 pulse, error=0.
//   5 'C' during WAIT, then done with 55 -> state=0, buf_clear pulse, result_valid stays 0, result unchanged.
//   6 TIMEOUT_WATCHDOG_EN, TIMEOUT_CYC=8, no alu_done -> ERR 8 cycles after WAIT entry; later alu_done ignored. Async reset mid-EXEC -> alu_start 0 at once, state=0.

Source files
------------

// File: rtl/calc_input_sequencer_if.sv
// calc_if: bundle between the command sequencer and its neighbours.
//   Receiver side : rx_valid, rx_data
//   ALU side      : alu_start/alu_ready request handshake, alu_op/alu_a/alu_b
//                   operands, alu_done/alu_result/alu_error completion
//   Display side  : result, result_valid strobe, buf_clear strobe
//   Status        : busy, error, state
// modport master : the sequencer (drives ALU request, result and status)
// modport slave  : the environment (receiver, ALU, display)
interface calc_if #(
  parameter int WIDTH = 16
);
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             alu_start;
  logic             alu_ready;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_done;
  logic [WIDTH-1:0] alu_result;
  logic             alu_error;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             buf_clear;
  logic             busy;
  logic             error;
  logic [2:0]       state;

  modport master (
    input  rx_valid, rx_data, alu_ready, alu_done, alu_result, alu_error,
    output alu_start, alu_op, alu_a, alu_b, result, result_valid,
           buf_clear, busy, error, state
  );

  modport slave (
    output rx_valid, rx_data, alu_ready, alu_done, alu_result, alu_error,
    input  alu_start, alu_op, alu_a, alu_b, result, result_valid,
           buf_clear, busy, error, state
  );
endinterface

// File: rtl/calc_input_sequencer.sv
// calc_input_sequencer: parses ASCII keys from the UART receiver into
// operand A, operator, operand B; runs the start/ready/done handshake with
// the ALU; publishes the result with a one-cycle strobe and issues
// display-buffer clear pulses.
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-low reset
//   bus    - calc_if.master (receiver bytes, ALU handshake, display, status)
// Parameters: WIDTH (operand width), MAX_DIGITS (digits kept per operand),
//   TIMEOUT_CYC (WAIT watchdog limit).
// Optional feature: define TIMEOUT_WATCHDOG_EN to enable the WAIT-state
//   watchdog; without it WAIT holds until alu_done.
module calc_input_sequencer #(
  parameter int WIDTH       = 16,
  parameter int MAX_DIGITS  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic   clk,
  input  logic   reset,
  calc_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OPA  = 3'd1,
    S_OPB  = 3'd2,
    S_EXEC = 3'd3,
    S_WAIT = 3'd4,
    S_SHOW = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam int                 CW  = $clog2(MAX_DIGITS + 1);
  localparam logic [WIDTH-1:0]   SAT = '1;
  localparam logic [WIDTH+3:0]   TEN = (WIDTH+4)'(10);
  localparam logic [CW-1:0]      CNT_MAX = CW'(MAX_DIGITS);

  state_t           r_state, w_state_nxt;
  logic             r_rx_valid_q;
  logic [WIDTH-1:0] r_a, r_b, r_result;
  logic [WIDTH-1:0] w_a_nxt, w_b_nxt, w_result_nxt;
  logic [1:0]       r_op, w_op_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_pend_clr, w_pend_nxt;
  logic             r_result_valid, w_rv_nxt;
  logic             r_buf_clear, w_bc_nxt;

  // acc*10 + d computed 4 bits wider so overflow is visible, then clamped
  function automatic logic [WIDTH-1:0] acc_digit(input logic [WIDTH-1:0] acc,
                                                 input logic [3:0] d);
    logic [WIDTH+3:0] t;
    t = ({4'd0, acc} * TEN) + {{WIDTH{1'b0}}, d};
    return (t > {4'd0, SAT}) ? SAT : t[WIDTH-1:0];
  endfunction

  // ---------------------------------------------------------------- decode
  logic       w_take, w_is_digit, w_is_op, w_is_eq, w_is_clr, w_acc_ok;
  logic [1:0] w_op_code;
  logic [3:0] w_digit;

  assign w_take     = bus.rx_valid & ~r_rx_valid_q;
  assign w_is_digit = w_take && (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
  assign w_is_op    = w_take && ((bus.rx_data == 8'h2B) || (bus.rx_data == 8'h2D) ||
                                 (bus.rx_data == 8'h2A) || (bus.rx_data == 8'h2F));
  assign w_is_eq    = w_take && ((bus.rx_data == 8'h3D) || (bus.rx_data == 8'h0D));
  assign w_is_clr   = w_take && ((bus.rx_data == 8'h43) || (bus.rx_data == 8'h63));
  // ASCII '0'..'9' carry the digit value in the low nibble
  assign w_digit    = bus.rx_data[3:0];
  assign w_acc_ok   = (r_cnt != CNT_MAX);

  always_comb begin
    w_op_code = 2'd0;
    case (bus.rx_data)
      8'h2B:   w_op_code = 2'd0;
      8'h2D:   w_op_code = 2'd1;
      8'h2A:   w_op_code = 2'd2;
      8'h2F:   w_op_code = 2'd3;
      default: w_op_code = 2'd0;
    endcase
  end

  // -------------------------------------------------------------- watchdog
  logic w_timeout;
`ifdef TIMEOUT_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_wd;

  // Held at zero outside WAIT, so it restarts on every WAIT entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_wd <= '0;
    else if (r_state != S_WAIT) r_wd <= '0;
    else                       r_wd <= r_wd + 1'b1;
  end

  assign w_timeout = (r_state == S_WAIT) && (r_wd == TW'(TIMEOUT_CYC - 1));
`else
  // Watchdog compiled out; this is a constant 0
  assign w_timeout = (TIMEOUT_CYC < 0);
`endif

  // ------------------------------------------------------- next-state logic
  logic w_pend_eff;
  // A clear arriving in the same cycle as alu_done still counts as pending
  assign w_pend_eff = r_pend_clr | w_is_clr;

  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_op_nxt     = r_op;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    w_pend_nxt   = r_pend_clr;
    w_rv_nxt     = 1'b0;
    w_bc_nxt     = 1'b0;

    case (r_state)
      S_IDLE, S_OPA, S_OPB, S_SHOW, S_ERR: begin
        if (w_is_clr) begin
          w_a_nxt     = '0;
          w_b_nxt     = '0;
          w_cnt_nxt   = '0;
          w_pend_nxt  = 1'b0;
          w_bc_nxt    = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          case (r_state)
            S_IDLE: begin
              if (w_is_digit) begin
                w_a_nxt     = {{(WIDTH-4){1'b0}}, w_digit};
                w_cnt_nxt   = CW'(1);
                w_state_nxt = S_OPA;
              end
            end
            S_OPA: begin
              if (w_is_digit && w_acc_ok) begin
                w_a_nxt   = acc_digit(r_a, w_digit);
                w_cnt_nxt = r_cnt + 1'b1;
              end else if (w_is_op) begin
                w_op_nxt    = w_op_code;
                w_b_nxt     = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_OPB;
              end
            end
            S_OPB: begin
              if (w_is_digit && w_acc_ok) begin
                w_b_nxt   = acc_digit(r_b, w_digit);
                w_cnt_nxt = r_cnt + 1'b1;
              end else if (w_is_op && (r_cnt == '0)) begin
                // operator typo fix before any B digit
                w_op_nxt = w_op_code;
              end else if (w_is_eq && (r_cnt != '0)) begin
                w_state_nxt = S_EXEC;
              end
            end
            S_SHOW: begin
              if (w_is_digit) begin
                w_a_nxt     = {{(WIDTH-4){1'b0}}, w_digit};
                w_b_nxt     = '0;
                w_cnt_nxt   = CW'(1);
                w_state_nxt = S_OPA;
              end else if (w_is_op) begin
                // chain: previous result becomes operand A
                w_a_nxt     = r_result;
                w_op_nxt    = w_op_code;
                w_b_nxt     = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_OPB;
              end
            end
            default: ;  // S_ERR: only a clear leaves
          endcase
        end
      end

      S_EXEC: begin
        if (w_is_clr) w_pend_nxt = 1'b1;
        // alu_start is asserted throughout EXEC
        if (bus.alu_ready) w_state_nxt = S_WAIT;
      end

      S_WAIT: begin
        if (w_is_clr) w_pend_nxt = 1'b1;
        if (bus.alu_done || w_timeout) begin
          if (w_pend_eff) begin
            w_a_nxt     = '0;
            w_b_nxt     = '0;
            w_cnt_nxt   = '0;
            w_pend_nxt  = 1'b0;
            w_bc_nxt    = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (!bus.alu_done || bus.alu_error) begin
            w_state_nxt = S_ERR;
          end else begin
            w_result_nxt = bus.alu_result;
            w_rv_nxt     = 1'b1;
            w_state_nxt  = S_SHOW;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_rx_valid_q   <= 1'b0;
      r_a            <= '0;
      r_b            <= '0;
      r_op           <= '0;
      r_cnt          <= '0;
      r_result       <= '0;
      r_pend_clr     <= 1'b0;
      r_result_valid <= 1'b0;
      r_buf_clear    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_rx_valid_q   <= bus.rx_valid;
      r_a            <= w_a_nxt;
      r_b            <= w_b_nxt;
      r_op           <= w_op_nxt;
      r_cnt          <= w_cnt_nxt;
      r_result       <= w_result_nxt;
      r_pend_clr     <= w_pend_nxt;
      r_result_valid <= w_rv_nxt;
      r_buf_clear    <= w_bc_nxt;
    end
  end

  // ---------------------------------------------------------------- outputs
  // Decoded straight from the state register so async reset drops it at once
  assign bus.alu_start    = (r_state == S_EXEC);
  assign bus.alu_op       = r_op;
  assign bus.alu_a        = r_a;
  assign bus.alu_b        = r_b;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.buf_clear    = r_buf_clear;
  assign bus.busy         = (r_state == S_EXEC) || (r_state == S_WAIT);
  assign bus.error        = (r_state == S_ERR);
  assign bus.state        = r_state;

endmodule
